// File: rtl/nios_cpu_div_pkg.sv
// Shared types and helpers for the Nios CPU multi-cycle divider.
package nios_cpu_div_pkg;

  // Default operand/result width of the divider datapath.
  localparam int DIV_WIDTH_DEFAULT = 32;

  // Control states of the divider sequencer.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

  // Width of the iteration counter: it must hold WIDTH-1.
  function automatic int divCntWidth(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/nios_cpu_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor magnitude and keep the difference when it
// does not underflow.
module nios_cpu_div_step
  import nios_cpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qBit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;

  // The partial remainder after k steps is below 2^k, so the shifted value
  // never reaches 2^WIDTH and the top bit of a WIDTH+1-bit difference is a
  // reliable borrow flag for the compare.
  always_comb begin
    w_shifted = {i_rem, i_bit};
    w_diff    = w_shifted - {1'b0, i_divisor};
    o_qBit    = ~w_diff[WIDTH];
    o_rem     = o_qBit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/nios_cpu_div_cell.sv
// Multi-cycle signed/unsigned integer divider for the Nios CPU datapath.
// Start/done handshake, fixed WIDTH+3 cycle latency, abortable by kill.
module nios_cpu_div_cell
  import nios_cpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_dividend,
  input  logic [WIDTH-1:0] div_divisor,
  input  logic             div_kill,
  output logic             div_busy,
  output logic             div_done,
  output logic [WIDTH-1:0] div_quotient,
  output logic [WIDTH-1:0] div_remainder,
  output logic             div_by_zero
);

  localparam int CW = divCntWidth(WIDTH);

  div_state_e r_state;
  div_state_e w_stateNext;

  // Operands as captured at acceptance.
  logic             r_signed;
  logic [WIDTH-1:0] r_dvdIn;
  logic [WIDTH-1:0] r_dvsIn;

  // Working registers: r_dvd shifts dividend bits out at the top while the
  // quotient bits shift in at the bottom, so it ends up holding |quotient|.
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvsAbs;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_qNeg;
  logic             r_rNeg;
  logic             r_byZero;

  // Architecturally visible results, held until the next completion.
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_byZeroOut;

  logic [WIDTH-1:0] w_dvdAbs;
  logic [WIDTH-1:0] w_dvsAbs;
  logic [WIDTH-1:0] w_remNext;
  logic             w_qBit;
  logic [WIDTH-1:0] w_quoFix;
  logic [WIDTH-1:0] w_remFix;

  nios_cpu_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[WIDTH-1]),
    .i_divisor (r_dvsAbs),
    .o_rem     (w_remNext),
    .o_qBit    (w_qBit)
  );

  // Operand magnitudes for the preparation step and sign fix-up of results.
  always_comb begin
    w_dvdAbs = (r_signed && r_dvdIn[WIDTH-1]) ? (~r_dvdIn + 1'b1) : r_dvdIn;
    w_dvsAbs = (r_signed && r_dvsIn[WIDTH-1]) ? (~r_dvsIn + 1'b1) : r_dvsIn;
    w_quoFix = r_qNeg ? (~r_dvd + 1'b1) : r_dvd;
    w_remFix = r_rNeg ? (~r_rem + 1'b1) : r_rem;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic; kill wins over start and aborts everything but DONE.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (div_start && !div_kill) begin
          w_stateNext = PREP;
        end
      end
      PREP: begin
        w_stateNext = div_kill ? IDLE : ITER;
      end
      ITER: begin
        if (div_kill) begin
          w_stateNext = IDLE;
        end else if (r_cnt == '0) begin
          w_stateNext = FIX;
        end
      end
      FIX: begin
        w_stateNext = div_kill ? IDLE : DONE;
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Handshake outputs decoded directly from the state.
  always_comb begin
    div_busy = 1'b0;
    div_done = 1'b0;
    case (r_state)
      PREP, ITER, FIX: div_busy = 1'b1;
      DONE:            div_done = 1'b1;
      default: begin
        div_busy = 1'b0;
        div_done = 1'b0;
      end
    endcase
  end

  // Datapath: capture, prepare magnitudes, iterate, then publish results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_signed    <= 1'b0;
      r_dvdIn     <= '0;
      r_dvsIn     <= '0;
      r_dvd       <= '0;
      r_dvsAbs    <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_qNeg      <= 1'b0;
      r_rNeg      <= 1'b0;
      r_byZero    <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_byZeroOut <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (div_start && !div_kill) begin
            r_signed <= div_signed;
            r_dvdIn  <= div_dividend;
            r_dvsIn  <= div_divisor;
          end
        end
        PREP: begin
          r_dvd    <= w_dvdAbs;
          r_dvsAbs <= w_dvsAbs;
          r_rem    <= '0;
          r_cnt    <= CW'(WIDTH - 1);
          r_qNeg   <= r_signed & (r_dvdIn[WIDTH-1] ^ r_dvsIn[WIDTH-1]);
          r_rNeg   <= r_signed & r_dvdIn[WIDTH-1];
          r_byZero <= (r_dvsIn == '0);
        end
        ITER: begin
          r_dvd <= {r_dvd[WIDTH-2:0], w_qBit};
          r_rem <= w_remNext;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        FIX: begin
          if (!div_kill) begin
            if (r_byZero) begin
              r_quotient  <= '1;
              r_remainder <= r_dvdIn;
            end else begin
              r_quotient  <= w_quoFix;
              r_remainder <= w_remFix;
            end
            r_byZeroOut <= r_byZero;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign div_quotient  = r_quotient;
  assign div_remainder = r_remainder;
  assign div_by_zero   = r_byZeroOut;

endmodule

// File: tb/tb_nios_cpu_div_cell.sv
// Self-checking bench for nios_cpu_div_cell: directed and random divisions
// through an expected-result queue, plus kill, ignored-start and reset cases.
module tb_nios_cpu_div_cell;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             div_start;
  logic             div_signed;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_kill;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;
  logic             div_by_zero;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             bz;
  } exp_t;

  exp_t             expQ[$];
  int               nCompared   = 0;
  int               nMismatched = 0;
  logic [WIDTH-1:0] lastQ = '0;
  logic [WIDTH-1:0] lastR = '0;
  logic             lastBz = 1'b0;

  nios_cpu_div_cell #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .div_start     (div_start),
    .div_signed    (div_signed),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_kill      (div_kill),
    .div_busy      (div_busy),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .div_by_zero   (div_by_zero)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t   e;
    longint sa;
    longint sb;
    if (b == '0) begin
      e.q = '1; e.r = a; e.bz = 1'b1;
    end else if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      e.q = WIDTH'(sa / sb);
      e.r = WIDTH'(sa % sb);
      e.bz = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.bz = 1'b0;
    end
    return e;
  endfunction

  task automatic pushExp(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r, input logic bz);
    exp_t e;
    e.q = q; e.r = r; e.bz = bz;
    expQ.push_back(e);
  endtask

  // Drives one request cycle (cycle 0) and returns positioned in cycle 1.
  task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    div_signed   = s;
    div_dividend = a;
    div_divisor  = b;
    div_start    = 1'b1;
    stepCycle();
    div_start    = 1'b0;
  endtask

  // Waits for done starting at cycle startCyc, then compares against the queue.
  task automatic checkOutput(input string name, input int startCyc);
    int   doneCyc = -1;
    int   busyBad = 0;
    exp_t e;
    for (int c = startCyc; c <= LAT + 4; c++) begin
      if (div_done === 1'b1) begin
        doneCyc = c;
        break;
      end
      if (div_busy !== 1'b1) busyBad++;
      stepCycle();
    end
    nCompared++;
    if (doneCyc !== LAT) begin
      nMismatched++;
      $display("[TB] FAIL %s done_cycle: got %0d expected %0d", name, doneCyc, LAT);
    end
    nCompared++;
    if (busyBad !== 0) begin
      nMismatched++;
      $display("[TB] FAIL %s busy_low_cycles: got %0d expected 0", name, busyBad);
    end
    if (expQ.size() == 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s scoreboard: got empty queue expected an entry", name);
      return;
    end
    e = expQ.pop_front();
    nCompared++;
    if (div_quotient !== e.q) begin
      nMismatched++;
      $display("[TB] FAIL %s quotient: got %h expected %h", name, div_quotient, e.q);
    end
    nCompared++;
    if (div_remainder !== e.r) begin
      nMismatched++;
      $display("[TB] FAIL %s remainder: got %h expected %h", name, div_remainder, e.r);
    end
    nCompared++;
    if (div_by_zero !== e.bz) begin
      nMismatched++;
      $display("[TB] FAIL %s by_zero: got %b expected %b", name, div_by_zero, e.bz);
    end
    lastQ = e.q; lastR = e.r; lastBz = e.bz;
    stepCycle();
    nCompared++;
    if ({div_done, div_busy} !== 2'b00 || div_quotient !== e.q) begin
      nMismatched++;
      $display("[TB] FAIL %s after_done: got done=%b busy=%b q=%h expected done=0 busy=0 q=%h",
               name, div_done, div_busy, div_quotient, e.q);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) stepCycle();
    nCompared++;
    if ({div_busy, div_done, div_by_zero} !== 3'b000 || div_quotient !== '0 || div_remainder !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_values: got busy=%b done=%b bz=%b q=%h r=%h expected all zero",
               div_busy, div_done, div_by_zero, div_quotient, div_remainder);
    end
    reset_n = 1'b1;
    repeat (2) stepCycle();
    nCompared++;
    if ({div_busy, div_done} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL idle_after_reset: got busy=%b done=%b expected 0 0", div_busy, div_done);
    end
  endtask

  task automatic test_unsigned();
    pushExp(32'd14, 32'd2, 1'b0);
    applyStimulus(1'b0, 32'd100, 32'd7);
    checkOutput("udiv_100_7", 1);
    pushExp(32'h7FFFFFFC, 32'd1, 1'b0);
    applyStimulus(1'b0, 32'hFFFFFFF9, 32'd2);
    checkOutput("udiv_fff9_2", 1);
    pushExp(32'd1, 32'd1, 1'b0);
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE);
    checkOutput("udiv_wide", 1);
  endtask

  task automatic test_signed();
    pushExp(32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2);
    checkOutput("sdiv_m7_2", 1);
    pushExp(32'hFFFFFFFD, 32'd1, 1'b0);
    applyStimulus(1'b1, 32'd7, 32'hFFFFFFFE);
    checkOutput("sdiv_7_m2", 1);
  endtask

  task automatic test_div_zero();
    pushExp(32'hFFFFFFFF, 32'd5, 1'b1);
    applyStimulus(1'b1, 32'd5, 32'd0);
    checkOutput("sdiv_by_zero", 1);
    pushExp(32'hFFFFFFFF, 32'd5, 1'b1);
    applyStimulus(1'b0, 32'd5, 32'd0);
    checkOutput("udiv_by_zero", 1);
    pushExp(32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1);
    applyStimulus(1'b1, 32'hFFFFFFFB, 32'd0);
    checkOutput("sdiv_neg_by_zero", 1);
  endtask

  task automatic test_overflow();
    pushExp(32'h80000000, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF);
    checkOutput("sdiv_min_m1", 1);
    pushExp(32'h80000000, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'h80000000, 32'd1);
    checkOutput("sdiv_min_1", 1);
  endtask

  task automatic test_kill();
    int doneSeen = 0;
    int heldBad  = 0;
    // Kill in the same cycle as start drops the request.
    div_kill = 1'b1;
    applyStimulus(1'b0, 32'd50, 32'd5);
    div_kill = 1'b0;
    nCompared++;
    if (div_busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL kill_beats_start: got busy=%b expected 0", div_busy);
    end
    // Kill in the middle of the iterations.
    applyStimulus(1'b0, 32'd100, 32'd7);
    repeat (9) stepCycle();
    div_kill = 1'b1;
    stepCycle();
    div_kill = 1'b0;
    nCompared++;
    if (div_busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL kill_busy_drop: got busy=%b expected 0", div_busy);
    end
    for (int c = 0; c < LAT + 5; c++) begin
      if (div_done === 1'b1) doneSeen++;
      if (div_quotient !== lastQ || div_remainder !== lastR || div_by_zero !== lastBz) heldBad++;
      stepCycle();
    end
    nCompared++;
    if (doneSeen !== 0) begin
      nMismatched++;
      $display("[TB] FAIL kill_no_done: got %0d done cycles expected 0", doneSeen);
    end
    nCompared++;
    if (heldBad !== 0) begin
      nMismatched++;
      $display("[TB] FAIL kill_outputs_held: got %0d changed cycles expected 0", heldBad);
    end
    pushExp(32'd3, 32'd0, 1'b0);
    applyStimulus(1'b0, 32'd9, 32'd3);
    checkOutput("kill_restart_9_3", 1);
  endtask

  task automatic test_start_ignored();
    expQ.push_back(model(1'b0, 32'd1000, 32'd33));
    applyStimulus(1'b0, 32'd1000, 32'd33);
    repeat (19) stepCycle();
    applyStimulus(1'b1, 32'd5, 32'd0);
    checkOutput("start_ignored", 21);
    stepCycle();
    nCompared++;
    if (div_busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL ignored_start_latched: got busy=%b expected 0", div_busy);
    end
  endtask

  task automatic test_reset_mid();
    int doneSeen = 0;
    applyStimulus(1'b0, 32'd100, 32'd7);
    repeat (14) stepCycle();
    reset_n = 1'b0;
    #1;
    nCompared++;
    if ({div_busy, div_done, div_by_zero} !== 3'b000 || div_quotient !== '0 || div_remainder !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_mid_values: got busy=%b done=%b bz=%b q=%h r=%h expected all zero",
               div_busy, div_done, div_by_zero, div_quotient, div_remainder);
    end
    stepCycle();
    stepCycle();
    reset_n = 1'b1;
    for (int c = 0; c < LAT + 2; c++) begin
      if (div_done === 1'b1 || div_busy === 1'b1) doneSeen++;
      stepCycle();
    end
    nCompared++;
    if (doneSeen !== 0) begin
      nMismatched++;
      $display("[TB] FAIL reset_mid_quiet: got %0d active cycles expected 0", doneSeen);
    end
    pushExp(32'd3, 32'd0, 1'b0);
    applyStimulus(1'b0, 32'd9, 32'd3);
    checkOutput("reset_mid_restart", 1);
  endtask

  task automatic test_back_to_back();
    logic             s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    for (int i = 0; i < 8; i++) begin
      s = 1'(($urandom_range(0, 1)));
      a = $urandom;
      b = (i % 3 == 0) ? WIDTH'($urandom_range(1, 20)) : $urandom;
      if (s && (i % 2 == 1)) b = ~b + 1'b1;
      if (i == 7) b = '0;
      expQ.push_back(model(s, a, b));
      applyStimulus(s, a, b);
      checkOutput("back_to_back", 1);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    div_start    = 1'b0;
    div_signed   = 1'b0;
    div_dividend = '0;
    div_divisor  = '0;
    div_kill     = 1'b0;
    #1;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_kill();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/nios_cpu_div_cell.md
Name: nios_cpu_div_cell

Overview:
Multi-cycle integer divider for the Nios CPU datapath. It computes quotient and remainder of two WIDTH-bit operands, signed or unsigned, using a radix-2 restoring algorithm. It is the inverse-operation companion to the multiplier partial-product cell. It is started and collected by the CPU execute/memory control through a start/done handshake, and can be killed on a pipeline flush.

Parameters:
WIDTH, 32, operand/result width in bits; must be >= 4.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
div_start  input  1  request; sampled only in IDLE
div_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with div_start
div_dividend  input  WIDTH  dividend; captured with div_start
div_divisor  input  WIDTH  divisor; captured with div_start
div_kill  input  1  synchronous abort of the in-flight operation
div_busy  output  1  high from the cycle after acceptance until DONE
div_done  output  1  one-cycle pulse; results valid in that cycle
div_quotient  output  WIDTH  registered quotient, held until the next acceptance
div_remainder  output  WIDTH  registered remainder, held until the next acceptance
div_by_zero  output  1  registered flag; valid with div_done, held with the results

Behaviour:
- Reset (async, reset_n=0): state=IDLE, div_busy=0, div_done=0, div_quotient=0, div_remainder=0, div_by_zero=0, iteration counter=0.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - div_start=1 and div_kill=0: capture operands and sign mode, go to PREP.
  - Otherwise stay in IDLE.
  - Kill beats start in the same cycle; the request is dropped.
- PREP (1 cycle):
  - Form absolute values when signed; else pass operands through.
  - Record q_neg = sign(dividend) XOR sign(divisor).
  - Record r_neg = sign(dividend).
  - Record by_zero = (divisor == 0).
  - Clear partial remainder; load counter = WIDTH-1.
- ITER (exactly WIDTH cycles, one quotient bit per cycle, MSB first):
  - r' = {r[WIDTH-2:0], next dividend bit}.
  - If r' >= |divisor|: r = r' - |divisor|, quotient bit = 1. Else r = r', quotient bit = 0.
  - Use a WIDTH+1-bit subtractor for the compare.
  - Counter decrements each cycle; exit to FIX on the cycle the counter is 0.
- FIX (1 cycle), results written to the output registers:
  - Signed: negate the quotient if q_neg; negate the remainder if r_neg.
  - by_zero overrides both results: quotient = all ones, remainder = original dividend, for both signed and unsigned.
- DONE (1 cycle): div_done=1, div_busy=0, then return to IDLE.
- Latency:
  - Start accepted in cycle 0.
  - div_busy=1 in cycles 1..WIDTH+2.
  - div_done=1 in cycle WIDTH+3 (cycle 35 for WIDTH=32).
  - Latency is fixed and data-independent, including divide-by-zero.
- Throughput: a new div_start is accepted in the cycle after DONE. Back-to-back gap = WIDTH+4 cycles.
- div_start while not in IDLE: ignored, with no side effects.
- Signed overflow, MIN / -1: quotient = MIN (0x80000000), remainder = 0. This falls out of the unsigned-magnitude path; no special case.
- Remainder sign follows the dividend; quotient truncates toward zero.
- div_kill in PREP, ITER or FIX:
  - Next state = IDLE; div_busy drops the next cycle.
  - No div_done.
  - Output registers keep their previous values.
- div_kill in DONE: ignored; the done pulse still occurs.
- Async reset mid-operation: immediate return to the reset values, with no done.

Decomposition:
- Shared package nios_cpu_div_pkg:
  - state enum (IDLE, PREP, ITER, FIX, DONE)
  - DIV_WIDTH_DEFAULT = 32
  - function giving counter width = clog2(WIDTH)
- One natural sub-module: nios_cpu_div_step. It is combinational and performs one restoring iteration: inputs partial remainder, dividend bit, |divisor|; outputs new remainder and quotient bit.

Test Plan:
- Unsigned 100 / 7, start at cycle 0 -> div_done only in cycle 35; quotient=14, remainder=2, div_by_zero=0; div_busy high in cycles 1..34.
- Signed -7 / 2 (0xFFFFFFF9 / 0x2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); unsigned 0xFFFFFFF9 / 2 -> quotient=0x7FFFFFFC, remainder=1.
- Divide by zero: 5 / 0, both signed and unsigned -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, done still in cycle 35.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0; signed 0x80000000 / 1 -> quotient=0x80000000, remainder=0.
- Kill and re-start:
  - Start 100/7, assert div_kill in cycle 10 -> div_busy=0 from cycle 11, no div_done, outputs keep the previous results.
  - Then start 9/3 -> quotient=3, remainder=0 with done 35 cycles after that start.
  - div_start pulsed in cycle 20 of an active operation -> no effect on its result.
- Reset mid-operation: reset_n low in cycle 15 for 2 cycles -> all outputs 0 immediately and no done; the next start after release completes normally.
